amb_touch_detect: RTL and testbench

//  Consumer side of the ambient-light/threshold interface. Takes the same DVI/CCD pixel stream

---
 rtl/amb_touch_detect.sv | 229 ++++++++++++++++++++++
 tb/tb_amb_touch_detect.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amb_touch_detect.sv
`timescale 1ns/1ps
// amb_touch_detect
//   Consumer side of the ambient-light/threshold interface. Each valid pixel has
//   the per-channel ambient shift removed from its |DVI-CCD| colour difference,
//   and the compensated FD^2 is compared against the frame's threshold to give a
//   per-pixel hit. Hits are counted per frame and a touch decision is published
//   with a one-cycle frame_done_o pulse.
//
//   Optional feature macro: AMB_TOUCH_BBOX_EN (adds the hit bounding-box outputs).
//
// Ports
//   clk_25, reset (sync, active-high)
//   valid_i, syncX_i, syncY_i           pixel qualifier and position
//   DVI_R/G/B_i, CCD_R/G/B_i            reference / camera colour (5/6/5 bit)
//   AMB_SHIFT_R/G/B_i, threshold_i      ambient block results, latched at (0,0)
//   hit_valid_o, hit_o, hit_x_o/y_o     per-pixel result, 3 cycles after valid_i
//   frame_done_o                        one-cycle pulse when a frame result is ready
//   hit_count_o, touch_o                last completed frame, held until next pulse
//   bbox_x0/y0/x1/y1_o                  (AMB_TOUCH_BBOX_EN) hit bounding box
module amb_touch_detect #(
  parameter logic [9:0]  H_LAST   = 10'd639,
  parameter logic [9:0]  V_LAST   = 10'd479,
  parameter logic [18:0] MIN_HITS = 19'd16
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [9:0]  syncX_i,
  input  logic [9:0]  syncY_i,
  input  logic [4:0]  DVI_R_i,
  input  logic [5:0]  DVI_G_i,
  input  logic [4:0]  DVI_B_i,
  input  logic [4:0]  CCD_R_i,
  input  logic [5:0]  CCD_G_i,
  input  logic [4:0]  CCD_B_i,
  input  logic [7:0]  AMB_SHIFT_R_i,
  input  logic [7:0]  AMB_SHIFT_G_i,
  input  logic [7:0]  AMB_SHIFT_B_i,
  input  logic [31:0] threshold_i,
  output logic        hit_valid_o,
  output logic        hit_o,
  output logic [9:0]  hit_x_o,
  output logic [9:0]  hit_y_o,
  output logic        frame_done_o,
  output logic [18:0] hit_count_o,
  output logic        touch_o
`ifdef AMB_TOUCH_BBOX_EN
  ,
  output logic [9:0]  bbox_x0_o,
  output logic [9:0]  bbox_y0_o,
  output logic [9:0]  bbox_x1_o,
  output logic [9:0]  bbox_y1_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Ambient value is mean|diff|*4; round to the 6-bit domain and saturate.
  function automatic logic [5:0] shift6(input logic [7:0] amb);
    logic [8:0] t;
    t = ({1'b0, amb} + 9'd2) >> 2;
    return (t > 9'd63) ? 6'd63 : t[5:0];
  endfunction

  // |ref-cam| minus ambient shift, clamped at zero.
  function automatic logic [5:0] comp_diff(input logic [5:0] ref6, input logic [5:0] cam6,
                                           input logic [5:0] sh);
    logic signed [6:0] raw;
    logic signed [6:0] comp;
    logic [5:0]        mag;
    raw  = $signed({1'b0, ref6}) - $signed({1'b0, cam6});
    mag  = raw[6] ? 6'(-raw) : raw[5:0];
    comp = $signed({1'b0, mag}) - $signed({1'b0, sh});
    return comp[6] ? 6'd0 : comp[5:0];
  endfunction

  function automatic logic [11:0] sq(input logic [5:0] d);
    return {6'd0, d} * {6'd0, d};
  endfunction

  function automatic logic [18:0] sat_inc(input logic [18:0] c);
    return (c == 19'h7FFFF) ? c : c + 19'd1;
  endfunction

  // Frame latch with bypass so pixel (0,0) already uses its own values.
  logic [5:0]  sh_r_lat, sh_g_lat, sh_b_lat;
  logic [31:0] thr_lat;
  logic        origin_in;
  logic [5:0]  sh_r_eff, sh_g_eff, sh_b_eff;
  logic [31:0] thr_eff;

  always_comb begin
    origin_in = valid_i && (syncX_i == 10'd0) && (syncY_i == 10'd0);
    sh_r_eff  = origin_in ? shift6(AMB_SHIFT_R_i) : sh_r_lat;
    sh_g_eff  = origin_in ? shift6(AMB_SHIFT_G_i) : sh_g_lat;
    sh_b_eff  = origin_in ? shift6(AMB_SHIFT_B_i) : sh_b_lat;
    thr_eff   = origin_in ? threshold_i : thr_lat;
  end

  logic        vld_p0, vld_p1, vld_p2;
  logic [9:0]  x_p0, y_p0, x_p1, y_p1, x_p2, y_p2;
  logic [5:0]  dvi_r_p0, dvi_g_p0, dvi_b_p0, ccd_r_p0, ccd_g_p0, ccd_b_p0;
  logic [5:0]  sh_r_p0, sh_g_p0, sh_b_p0;
  logic [5:0]  d_r_p1, d_g_p1, d_b_p1;
  logic [13:0] fd2_p2;
  logic [31:0] thr_p0, thr_p1, thr_p2;

  // Threshold travels with each pixel so a new frame's value never reaches
  // the previous frame's pixels still in flight.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      sh_r_lat <= '0; sh_g_lat <= '0; sh_b_lat <= '0; thr_lat <= '0;
      vld_p0 <= 1'b0; vld_p1 <= 1'b0; vld_p2 <= 1'b0;
      x_p0 <= '0; y_p0 <= '0; x_p1 <= '0; y_p1 <= '0; x_p2 <= '0; y_p2 <= '0;
      dvi_r_p0 <= '0; dvi_g_p0 <= '0; dvi_b_p0 <= '0;
      ccd_r_p0 <= '0; ccd_g_p0 <= '0; ccd_b_p0 <= '0;
      sh_r_p0 <= '0; sh_g_p0 <= '0; sh_b_p0 <= '0;
      d_r_p1 <= '0; d_g_p1 <= '0; d_b_p1 <= '0;
      fd2_p2 <= '0; thr_p0 <= '0; thr_p1 <= '0; thr_p2 <= '0;
    end else begin
      if (origin_in) begin
        sh_r_lat <= sh_r_eff; sh_g_lat <= sh_g_eff; sh_b_lat <= sh_b_eff;
        thr_lat  <= thr_eff;
      end
      // S1: register inputs, R/B widened to the 6-bit domain
      vld_p0 <= valid_i;
      if (valid_i) begin
        x_p0 <= syncX_i; y_p0 <= syncY_i;
        dvi_r_p0 <= {DVI_R_i, 1'b0}; dvi_g_p0 <= DVI_G_i; dvi_b_p0 <= {DVI_B_i, 1'b0};
        ccd_r_p0 <= {CCD_R_i, 1'b0}; ccd_g_p0 <= CCD_G_i; ccd_b_p0 <= {CCD_B_i, 1'b0};
        sh_r_p0 <= sh_r_eff; sh_g_p0 <= sh_g_eff; sh_b_p0 <= sh_b_eff;
        thr_p0  <= thr_eff;
      end
      // S2: compensated per-channel difference
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        x_p1 <= x_p0; y_p1 <= y_p0; thr_p1 <= thr_p0;
        d_r_p1 <= comp_diff(dvi_r_p0, ccd_r_p0, sh_r_p0);
        d_g_p1 <= comp_diff(dvi_g_p0, ccd_g_p0, sh_g_p0);
        d_b_p1 <= comp_diff(dvi_b_p0, ccd_b_p0, sh_b_p0);
      end
      // S3: FD^2
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        x_p2 <= x_p1; y_p2 <= y_p1; thr_p2 <= thr_p1;
        fd2_p2 <= {2'b00, sq(d_r_p1)} + {2'b00, sq(d_g_p1)} + {2'b00, sq(d_b_p1)};
      end
    end
  end

  // S4: strict compare and frame-position decode
  logic        hit_p3, origin_p3, last_p3;
  logic [18:0] cnt, cnt_nx;
  state_t      state;

  always_comb begin
    hit_p3    = vld_p2 && ({18'd0, fd2_p2} > thr_p2);
    origin_p3 = vld_p2 && (x_p2 == 10'd0) && (y_p2 == 10'd0);
    last_p3   = vld_p2 && (x_p2 == H_LAST) && (y_p2 == V_LAST);
    cnt_nx    = hit_p3 ? sat_inc(cnt) : cnt;
  end

  assign hit_valid_o = vld_p2;
  assign hit_o       = hit_p3;
  assign hit_x_o     = x_p2;
  assign hit_y_o     = y_p2;

  // Frame boundaries are taken at the compare stage, so in-flight pixels of
  // the old frame are never counted into the new one. A (0,0) always starts
  // a fresh count that already includes its own hit.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      state <= IDLE; cnt <= '0;
      frame_done_o <= 1'b0; hit_count_o <= '0; touch_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (origin_p3) begin
        state <= RUN;
        cnt   <= {18'd0, hit_p3};
      end else begin
        case (state)
          RUN: begin
            cnt <= cnt_nx;
            if (last_p3) begin
              state        <= DONE;
              frame_done_o <= 1'b1;
              hit_count_o  <= cnt_nx;
              touch_o      <= (cnt_nx >= MIN_HITS);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef AMB_TOUCH_BBOX_EN
  logic [9:0] bx0, by0, bx1, by1;
  logic [9:0] bx0_nx, by0_nx, bx1_nx, by1_nx;

  always_comb begin
    bx0_nx = (hit_p3 && (x_p2 < bx0)) ? x_p2 : bx0;
    by0_nx = (hit_p3 && (y_p2 < by0)) ? y_p2 : by0;
    bx1_nx = (hit_p3 && (x_p2 > bx1)) ? x_p2 : bx1;
    by1_nx = (hit_p3 && (y_p2 > by1)) ? y_p2 : by1;
  end

  always_ff @(posedge clk_25) begin
    if (reset) begin
      bx0 <= '0; by0 <= '0; bx1 <= '0; by1 <= '0;
      bbox_x0_o <= '0; bbox_y0_o <= '0; bbox_x1_o <= '0; bbox_y1_o <= '0;
    end else if (origin_p3) begin
      // Empty box is min=3FF/max=0; the origin pixel itself sits at (0,0).
      bx0 <= hit_p3 ? 10'd0 : 10'h3FF;
      by0 <= hit_p3 ? 10'd0 : 10'h3FF;
      bx1 <= '0;
      by1 <= '0;
    end else if (state == RUN) begin
      bx0 <= bx0_nx; by0 <= by0_nx; bx1 <= bx1_nx; by1 <= by1_nx;
      if (last_p3) begin
        bbox_x0_o <= bx0_nx; bbox_y0_o <= by0_nx;
        bbox_x1_o <= bx1_nx; bbox_y1_o <= by1_nx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_amb_touch_detect.sv
`timescale 1ns/1ps
// Bench for amb_touch_detect on a reduced 16x8 frame. A pixel-level model
// predicts every output cycle by cycle; literal checks pin key frame results.
module tb_amb_touch_detect;
  localparam logic [9:0] HL = 10'd15;
  localparam logic [9:0] VL = 10'd7;
  localparam int W    = int'(HL) + 1;
  localparam int NPIX = W * (int'(VL) + 1);
  localparam int MAXC = 4096;

  logic        clk_25 = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0;
  logic [9:0]  syncX_i = '0, syncY_i = '0;
  logic [4:0]  DVI_R_i = '0, DVI_B_i = '0, CCD_R_i = '0, CCD_B_i = '0;
  logic [5:0]  DVI_G_i = '0, CCD_G_i = '0;
  logic [7:0]  AMB_SHIFT_R_i = '0, AMB_SHIFT_G_i = '0, AMB_SHIFT_B_i = '0;
  logic [31:0] threshold_i = '0;
  logic        hit_valid_o, hit_o, frame_done_o, touch_o;
  logic [9:0]  hit_x_o, hit_y_o;
  logic [18:0] hit_count_o;
`ifdef AMB_TOUCH_BBOX_EN
  logic [9:0]  bbox_x0_o, bbox_y0_o, bbox_x1_o, bbox_y1_o;
`endif

  amb_touch_detect #(.H_LAST(HL), .V_LAST(VL), .MIN_HITS(19'd16)) dut (
    .clk_25(clk_25), .reset(reset), .valid_i(valid_i),
    .syncX_i(syncX_i), .syncY_i(syncY_i),
    .DVI_R_i(DVI_R_i), .DVI_G_i(DVI_G_i), .DVI_B_i(DVI_B_i),
    .CCD_R_i(CCD_R_i), .CCD_G_i(CCD_G_i), .CCD_B_i(CCD_B_i),
    .AMB_SHIFT_R_i(AMB_SHIFT_R_i), .AMB_SHIFT_G_i(AMB_SHIFT_G_i), .AMB_SHIFT_B_i(AMB_SHIFT_B_i),
    .threshold_i(threshold_i),
    .hit_valid_o(hit_valid_o), .hit_o(hit_o), .hit_x_o(hit_x_o), .hit_y_o(hit_y_o),
    .frame_done_o(frame_done_o), .hit_count_o(hit_count_o), .touch_o(touch_o)
`ifdef AMB_TOUCH_BBOX_EN
    , .bbox_x0_o(bbox_x0_o), .bbox_y0_o(bbox_y0_o),
    .bbox_x1_o(bbox_x1_o), .bbox_y1_o(bbox_y1_o)
`endif
  );

  always #5 clk_25 = ~clk_25;

  int cyc = 0;
  always @(posedge clk_25) cyc <= cyc + 1;

  // Expected outputs indexed by the cycle in which they must be visible.
  bit ev[MAXC];
  bit eh[MAXC];
  int ex[MAXC];
  int ey[MAXC];
  bit ed[MAXC];
  int ecnt[MAXC];
  bit erst[MAXC];
  int eb[MAXC][4];

  int n_pass = 0, n_total = 0, n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Model state: frame-latched parameters and the current frame's tally.
  int     lat_sr, lat_sg, lat_sb;
  longint lat_thr;
  bit     in_frame;
  int     m_cnt;
  int     m_b[4];

  int     p_x, p_y, p_dr, p_dg, p_db, p_cr, p_cg, p_cb, p_ar, p_ag, p_ab;
  longint p_thr;

  function automatic int shift6m(input int a);
    int s;
    s = (a + 2) / 4;
    return (s > 63) ? 63 : s;
  endfunction

  function automatic int dsq(input int p, input int q, input int s);
    int d;
    d = ((p > q) ? p - q : q - p) - s;
    if (d < 0) d = 0;
    return d * d;
  endfunction

  task automatic step(input bit v, input bit rst);
    int  k, t, fd2;
    bit  h;
    @(posedge clk_25);
    #1;
    reset = rst; valid_i = v;
    syncX_i = 10'(p_x); syncY_i = 10'(p_y);
    DVI_R_i = 5'(p_dr); DVI_G_i = 6'(p_dg); DVI_B_i = 5'(p_db);
    CCD_R_i = 5'(p_cr); CCD_G_i = 6'(p_cg); CCD_B_i = 5'(p_cb);
    AMB_SHIFT_R_i = 8'(p_ar); AMB_SHIFT_G_i = 8'(p_ag); AMB_SHIFT_B_i = 8'(p_ab);
    threshold_i = p_thr[31:0];
    k = cyc;
    if (k + 6 >= MAXC) begin
      $display("FAIL cycle_budget cycle %0d: got %0d, expected below %0d", k, k, MAXC - 6);
      $fatal(1, "cycle budget exhausted");
    end
    if (rst) begin
      for (int i = k + 1; i <= k + 5; i++) begin ev[i] = 0; ed[i] = 0; end
      erst[k + 1] = 1;
      lat_sr = 0; lat_sg = 0; lat_sb = 0; lat_thr = 0;
      in_frame = 0; m_cnt = 0;
    end else if (v) begin
      if (p_x == 0 && p_y == 0) begin
        lat_sr = shift6m(p_ar); lat_sg = shift6m(p_ag); lat_sb = shift6m(p_ab);
        lat_thr = p_thr;
      end
      fd2 = dsq(2 * p_dr, 2 * p_cr, lat_sr) + dsq(p_dg, p_cg, lat_sg) + dsq(2 * p_db, 2 * p_cb, lat_sb);
      h = (longint'(fd2) > lat_thr);
      t = k + 3;
      ev[t] = 1; eh[t] = h; ex[t] = p_x; ey[t] = p_y;
      if (p_x == 0 && p_y == 0) begin
        in_frame = 1; m_cnt = h ? 1 : 0;
        m_b = h ? '{0, 0, 0, 0} : '{1023, 1023, 0, 0};
      end else if (in_frame) begin
        if (h) begin
          if (m_cnt < 524287) m_cnt++;
          if (p_x < m_b[0]) m_b[0] = p_x;
          if (p_y < m_b[1]) m_b[1] = p_y;
          if (p_x > m_b[2]) m_b[2] = p_x;
          if (p_y > m_b[3]) m_b[3] = p_y;
        end
        if (p_x == int'(HL) && p_y == int'(VL)) begin
          ed[t + 1] = 1; ecnt[t + 1] = m_cnt;
          for (int j = 0; j < 4; j++) eb[t + 1][j] = m_b[j];
          in_frame = 0;
        end
      end
    end
  endtask

  // Pixel patterns; second half of a frame uses thr_b and altered ambient values.
  task automatic set_pixel(input int mode, input int idx, input longint thr_a, input longint thr_b);
    p_x = idx % W; p_y = idx / W;
    p_dr = (p_x + 3 * p_y) % 32; p_dg = (p_x + p_y) % 32; p_db = (2 * p_x + p_y) % 32;
    p_cr = p_dr; p_cg = p_dg; p_cb = p_db;
    p_ar = 0; p_ag = 0; p_ab = 0;
    p_thr = (idx >= NPIX / 2) ? thr_b : thr_a;
    case (mode)
      1: begin
        p_ag = (idx >= NPIX / 2) ? 0 : 8;
        if ((p_y == 0 || p_y == 5) && p_x < 10) p_cg = p_dg + 10;
      end
      2: begin
        p_dg = (p_dg * 2 + p_y) % 64;
        p_cr = (p_dr * 5 + 7) % 32; p_cg = (p_dg * 3 + p_x) % 64; p_cb = (p_db + p_y * 3) % 32;
        p_ar = (p_x * 37 + p_y * 11 + 255) % 256;
        p_ag = (p_x * 13 + 20) % 256; p_ab = (p_y * 29 + 100) % 256;
      end
      3: if ((p_x == 3 && p_y == 2) || (p_x == 12 && p_y == 6)) p_cg = p_dg + 20;
      4: begin p_dr = 31; p_dg = 63; p_db = 31; p_cr = 0; p_cg = 0; p_cb = 0; end
      default: ;
    endcase
  endtask

  task automatic run_frame(input int mode, input longint thr_a, input longint thr_b,
                           input int n_pix, input bit bubbles, input bit rst_end);
    for (int idx = 0; idx < n_pix; idx++) begin
      set_pixel(mode, idx, thr_a, thr_b);
      step(1, 0);
      if (bubbles && (idx % 2 == 1)) step(0, 0);
    end
    if (rst_end) begin step(0, 1); step(0, 1); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  // Per-cycle comparison against the model.
  initial begin : compare
    int c, h_cnt;
    int h_b[4];
    h_cnt = 0; h_b = '{0, 0, 0, 0};
    forever begin
      @(negedge clk_25);
      c = cyc;
      if (c >= 1 && c < MAXC) begin
        if (erst[c]) begin h_cnt = 0; h_b = '{0, 0, 0, 0}; end
        if (ed[c]) begin
          h_cnt = ecnt[c];
          for (int j = 0; j < 4; j++) h_b[j] = eb[c][j];
        end
        chk("hit_valid", hit_valid_o, ev[c]);
        chk("hit", hit_o, ev[c] ? eh[c] : 1'b0);
        if (ev[c]) begin
          chk("hit_x", hit_x_o, ex[c]);
          chk("hit_y", hit_y_o, ey[c]);
        end
        chk("frame_done", frame_done_o, ed[c]);
        chk("hit_count", hit_count_o, h_cnt);
        chk("touch", touch_o, h_cnt >= 16);
`ifdef AMB_TOUCH_BBOX_EN
        chk("bbox_x0", bbox_x0_o, h_b[0]);
        chk("bbox_y0", bbox_y0_o, h_b[1]);
        chk("bbox_x1", bbox_x1_o, h_b[2]);
        chk("bbox_y1", bbox_y1_o, h_b[3]);
`endif
        if (frame_done_o === 1'b1) n_done++;
      end
    end
  end

  initial begin : main
    int d0;
    p_x = 0; p_y = 0; p_dr = 0; p_dg = 0; p_db = 0; p_cr = 0; p_cg = 0; p_cb = 0;
    p_ar = 0; p_ag = 0; p_ab = 0; p_thr = 0;
    lat_sr = 0; lat_sg = 0; lat_sb = 0; lat_thr = 0; in_frame = 0; m_cnt = 0;
    m_b = '{0, 0, 0, 0};

    // Reset for two cycles, then quiet pixels that never open a frame.
    step(0, 1); step(0, 1);
    idle(3);
    @(negedge clk_25);
    chk("lit_rst_count", hit_count_o, 0);
    chk("lit_rst_touch", touch_o, 0);
    chk("lit_rst_valid", hit_valid_o, 0);
    chk("lit_rst_done", frame_done_o, 0);
    p_x = int'(HL); p_y = int'(VL); p_dg = 40; p_cg = 0; p_thr = 0;
    step(1, 0);
    p_x = 5; p_y = 3;
    step(1, 0);
    idle(6);
    chk("lit_no_early_done", n_done, 0);

    // Model pin: G diff 10 minus shift6(8)=2 gives FD2 64.
    chk("lit_model_fd2", dsq(20, 30, shift6m(8)), 64);
    chk("lit_model_shift_sat", shift6m(255), 63);

    // Identical colours, threshold 0.
    d0 = n_done;
    run_frame(0, 0, 0, NPIX, 0, 0);
    idle(6);
    chk("lit_eq_count", hit_count_o, 0);
    chk("lit_eq_touch", touch_o, 0);
    chk("lit_eq_done", n_done - d0, 1);

    // 20 hits of FD2=64: threshold 63 then 64, back to back, then 63 alone.
    d0 = n_done;
    run_frame(1, 63, 63, NPIX, 0, 0);
    run_frame(1, 64, 64, NPIX, 0, 0);
    idle(6);
    chk("lit_thr64_count", hit_count_o, 0);
    chk("lit_b2b_done", n_done - d0, 2);
    run_frame(1, 63, 63, NPIX, 0, 0);
    idle(6);
    chk("lit_thr63_count", hit_count_o, 20);
    chk("lit_thr63_touch", touch_o, 1);

    // Mid-frame threshold/shift change is ignored; bubbles between pixels.
    run_frame(1, 64, 0, NPIX, 1, 0);
    idle(6);
    chk("lit_midchg_count", hit_count_o, 0);
    run_frame(1, 63, 200, NPIX, 1, 0);
    idle(6);
    chk("lit_midchg63_count", hit_count_o, 20);

    // Reset mid-frame, then a mixed-colour full frame.
    d0 = n_done;
    run_frame(1, 63, 63, 40, 0, 1);
    run_frame(2, 500, 500, NPIX, 0, 0);
    idle(6);
    chk("lit_rst_mid_done", n_done - d0, 1);

    // Restart: (0,0) before the last pixel drops the partial frame.
    d0 = n_done;
    run_frame(1, 63, 63, 50, 0, 0);
    run_frame(1, 63, 63, NPIX, 0, 0);
    idle(6);
    chk("lit_restart_done", n_done - d0, 1);
    chk("lit_restart_count", hit_count_o, 20);

    // Maximum FD2 = 3844+3969+3844 = 11657 against strict compare.
    run_frame(4, 11656, 11656, NPIX, 0, 0);
    idle(6);
    chk("lit_max_count", hit_count_o, NPIX);
    chk("lit_max_touch", touch_o, 1);
    run_frame(4, 11657, 11657, NPIX, 0, 0);
    idle(6);
    chk("lit_max_eq_count", hit_count_o, 0);

    // Two isolated hits, then a frame with none.
    run_frame(3, 63, 63, NPIX, 0, 0);
    idle(6);
    chk("lit_bbox_count", hit_count_o, 2);
`ifdef AMB_TOUCH_BBOX_EN
    chk("lit_bbox_x0", bbox_x0_o, 3);
    chk("lit_bbox_y0", bbox_y0_o, 2);
    chk("lit_bbox_x1", bbox_x1_o, 12);
    chk("lit_bbox_y1", bbox_y1_o, 6);
`endif
    run_frame(0, 0, 0, NPIX, 0, 0);
    idle(6);
    chk("lit_nohit_count", hit_count_o, 0);
`ifdef AMB_TOUCH_BBOX_EN
    chk("lit_nohit_x0", bbox_x0_o, 10'h3FF);
    chk("lit_nohit_y0", bbox_y0_o, 10'h3FF);
    chk("lit_nohit_x1", bbox_x1_o, 0);
    chk("lit_nohit_y1", bbox_y1_o, 0);
`endif

    idle(2);
    @(negedge clk_25);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
